// File: rtl/rx_fsm.sv
// rx_fsm: 8N1 UART receiver with mid-bit sampling; define RX_PARITY_EN for an even-parity bit before stop
`timescale 1us / 1ns
module rx_fsm #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
`ifdef RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t state;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
`ifdef RX_PARITY_EN
  logic par;
`endif
  logic tick;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef RX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      rx_m       <= RX;
      rx_s       <= rx_m;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START:
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
            busy  <= !rx_s;
          end
        DATA:
          if (tick) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + 1'b1;
`ifdef RX_PARITY_EN
            if (idx == 3'd7) state <= PARITY;
`else
            if (idx == 3'd7) state <= STOP;
`endif
          end
`ifdef RX_PARITY_EN
        PARITY:
          if (tick) begin
            cnt   <= '0;
            par   <= rx_s;
            state <= STOP;
          end
`endif
        STOP:
          if (tick) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shift;
              valid    <= 1'b1;
`ifdef RX_PARITY_EN
              parity_err <= (^shift) ^ par;
`endif
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
